// File: rtl/multisim_axi_limiter_pkg.sv
// rtl/multisim_axi_limiter_pkg.sv - shared constants and helpers for the AXI outstanding limiter
package multisim_axi_limiter_pkg;

  localparam int SKID_DEPTH = 2;

  function automatic int cnt_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/multisim_axi_skid.sv
// rtl/multisim_axi_skid.sv - two-entry registered skid buffer, one beat per cycle, order preserving
module multisim_axi_skid
  import multisim_axi_limiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(SKID_DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             rdy_q;
  logic             push;
  logic             pop;

  assign in_ready  = rdy_q;
  assign out_valid = (cnt != '0);
  assign out_data  = head;
  assign push      = in_valid && rdy_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)
      cnt_nxt = cnt + ONE;
    else if (pop && !push)
      cnt_nxt = cnt - ONE;
  end

  // head is only rewritten on a pop or when empty, so it holds steady while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rdy_q <= 1'b0;
      head  <= '0;
      tail  <= '0;
    end else begin
      cnt   <= cnt_nxt;
      rdy_q <= (cnt_nxt != FULL);
      if (pop) begin
        head <= (cnt == FULL) ? tail : in_data;
        if (push)
          tail <= in_data;
      end else if (push) begin
        if (cnt == '0)
          head <= in_data;
        else
          tail <= in_data;
      end
    end
  end

endmodule

// File: rtl/multisim_axi_outstanding_limiter.sv
// rtl/multisim_axi_outstanding_limiter.sv - skid-buffered AXI pass-through capping in-flight reads/writes
// Define MULTISIM_AXI_LIMITER_CHECK_EN to build the sticky o_err protocol monitor.
module multisim_axi_outstanding_limiter
  import multisim_axi_limiter_pkg::*;
#(
  parameter int AW_WIDTH           = 64,
  parameter int W_WIDTH            = 73,
  parameter int B_WIDTH            = 6,
  parameter int AR_WIDTH           = 64,
  parameter int R_WIDTH            = 71,
  parameter int R_LAST_BIT         = 0,
  parameter int MAX_WR_OUTSTANDING = 4,
  parameter int MAX_RD_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW_WIDTH-1:0] i_axi_s_aw,
  input  logic                i_axi_s_awvalid,
  output logic                o_axi_s_awready,
  input  logic [W_WIDTH-1:0]  i_axi_s_w,
  input  logic                i_axi_s_wvalid,
  output logic                o_axi_s_wready,
  output logic [B_WIDTH-1:0]  o_axi_s_b,
  output logic                o_axi_s_bvalid,
  input  logic                i_axi_s_bready,
  input  logic [AR_WIDTH-1:0] i_axi_s_ar,
  input  logic                i_axi_s_arvalid,
  output logic                o_axi_s_arready,
  output logic [R_WIDTH-1:0]  o_axi_s_r,
  output logic                o_axi_s_rvalid,
  input  logic                i_axi_s_rready,
  output logic [AW_WIDTH-1:0] o_axi_m_aw,
  output logic                o_axi_m_awvalid,
  input  logic                i_axi_m_awready,
  output logic [W_WIDTH-1:0]  o_axi_m_w,
  output logic                o_axi_m_wvalid,
  input  logic                i_axi_m_wready,
  input  logic [B_WIDTH-1:0]  i_axi_m_b,
  input  logic                i_axi_m_bvalid,
  output logic                o_axi_m_bready,
  output logic [AR_WIDTH-1:0] o_axi_m_ar,
  output logic                o_axi_m_arvalid,
  input  logic                i_axi_m_arready,
  input  logic [R_WIDTH-1:0]  i_axi_m_r,
  input  logic                i_axi_m_rvalid,
  output logic                o_axi_m_rready,
  output logic                o_err
);

  localparam int WCW = cnt_width(MAX_WR_OUTSTANDING);
  localparam int RCW = cnt_width(MAX_RD_OUTSTANDING);
  localparam logic [WCW-1:0] WR_MAX = WCW'(MAX_WR_OUTSTANDING);
  localparam logic [RCW-1:0] RD_MAX = RCW'(MAX_RD_OUTSTANDING);
  localparam logic [WCW-1:0] WR_ONE = WCW'(1);
  localparam logic [RCW-1:0] RD_ONE = RCW'(1);

  logic [WCW-1:0] wr_cnt;
  logic [RCW-1:0] rd_cnt;
  logic aw_vld, ar_vld, wr_open, rd_open;
  logic aw_hs, ar_hs, b_hs, r_last_hs, wr_udf, rd_udf;

  assign wr_open         = (wr_cnt != WR_MAX);
  assign rd_open         = (rd_cnt != RD_MAX);
  assign o_axi_m_awvalid = aw_vld && wr_open;
  assign o_axi_m_arvalid = ar_vld && rd_open;

  multisim_axi_skid #(.WIDTH(AW_WIDTH)) u_aw (
    .clk(clk), .rst_n(rst_n),
    .in_data(i_axi_s_aw), .in_valid(i_axi_s_awvalid), .in_ready(o_axi_s_awready),
    .out_data(o_axi_m_aw), .out_valid(aw_vld), .out_ready(i_axi_m_awready && wr_open)
  );

  multisim_axi_skid #(.WIDTH(W_WIDTH)) u_w (
    .clk(clk), .rst_n(rst_n),
    .in_data(i_axi_s_w), .in_valid(i_axi_s_wvalid), .in_ready(o_axi_s_wready),
    .out_data(o_axi_m_w), .out_valid(o_axi_m_wvalid), .out_ready(i_axi_m_wready)
  );

  multisim_axi_skid #(.WIDTH(B_WIDTH)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(i_axi_m_b), .in_valid(i_axi_m_bvalid), .in_ready(o_axi_m_bready),
    .out_data(o_axi_s_b), .out_valid(o_axi_s_bvalid), .out_ready(i_axi_s_bready)
  );

  multisim_axi_skid #(.WIDTH(AR_WIDTH)) u_ar (
    .clk(clk), .rst_n(rst_n),
    .in_data(i_axi_s_ar), .in_valid(i_axi_s_arvalid), .in_ready(o_axi_s_arready),
    .out_data(o_axi_m_ar), .out_valid(ar_vld), .out_ready(i_axi_m_arready && rd_open)
  );

  multisim_axi_skid #(.WIDTH(R_WIDTH)) u_r (
    .clk(clk), .rst_n(rst_n),
    .in_data(i_axi_m_r), .in_valid(i_axi_m_rvalid), .in_ready(o_axi_m_rready),
    .out_data(o_axi_s_r), .out_valid(o_axi_s_rvalid), .out_ready(i_axi_s_rready)
  );

  assign aw_hs     = o_axi_m_awvalid && i_axi_m_awready;
  assign ar_hs     = o_axi_m_arvalid && i_axi_m_arready;
  assign b_hs      = i_axi_m_bvalid && o_axi_m_bready;
  assign r_last_hs = i_axi_m_rvalid && o_axi_m_rready && i_axi_m_r[R_LAST_BIT];
  assign wr_udf    = b_hs && !aw_hs && (wr_cnt == '0);
  assign rd_udf    = r_last_hs && !ar_hs && (rd_cnt == '0);

  // a response arriving with nothing outstanding saturates at zero rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (aw_hs && !b_hs)
        wr_cnt <= wr_cnt + WR_ONE;
      else if (b_hs && !aw_hs && !wr_udf)
        wr_cnt <= wr_cnt - WR_ONE;
      if (ar_hs && !r_last_hs)
        rd_cnt <= rd_cnt + RD_ONE;
      else if (r_last_hs && !ar_hs && !rd_udf)
        rd_cnt <= rd_cnt - RD_ONE;
    end
  end

`ifdef MULTISIM_AXI_LIMITER_CHECK_EN
  logic                err_q;
  logic [4:0]          pend_q;
  logic [4:0]          viol;
  logic [AW_WIDTH-1:0] aw_prev;
  logic [W_WIDTH-1:0]  w_prev;
  logic [B_WIDTH-1:0]  b_prev;
  logic [AR_WIDTH-1:0] ar_prev;
  logic [R_WIDTH-1:0]  r_prev;

  // a beat offered last cycle without ready must reappear unchanged this cycle
  always_comb begin
    viol    = '0;
    viol[0] = pend_q[0] && (!o_axi_m_awvalid || (o_axi_m_aw != aw_prev));
    viol[1] = pend_q[1] && (!o_axi_m_wvalid || (o_axi_m_w != w_prev));
    viol[2] = pend_q[2] && (!i_axi_m_bvalid || (i_axi_m_b != b_prev));
    viol[3] = pend_q[3] && (!o_axi_m_arvalid || (o_axi_m_ar != ar_prev));
    viol[4] = pend_q[4] && (!i_axi_m_rvalid || (i_axi_m_r != r_prev));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      pend_q  <= '0;
      aw_prev <= '0;
      w_prev  <= '0;
      b_prev  <= '0;
      ar_prev <= '0;
      r_prev  <= '0;
    end else begin
      pend_q  <= {i_axi_m_rvalid && !o_axi_m_rready, o_axi_m_arvalid && !i_axi_m_arready,
                  i_axi_m_bvalid && !o_axi_m_bready, o_axi_m_wvalid && !i_axi_m_wready,
                  o_axi_m_awvalid && !i_axi_m_awready};
      aw_prev <= o_axi_m_aw;
      w_prev  <= o_axi_m_w;
      b_prev  <= i_axi_m_b;
      ar_prev <= o_axi_m_ar;
      r_prev  <= i_axi_m_r;
      if (wr_udf || rd_udf || (viol != '0))
        err_q <= 1'b1;
      if (wr_udf)  $error("multisim_axi_outstanding_limiter: B underflow");
      if (rd_udf)  $error("multisim_axi_outstanding_limiter: R underflow");
      if (viol[0]) $error("multisim_axi_outstanding_limiter: AW unstable before ready");
      if (viol[1]) $error("multisim_axi_outstanding_limiter: W unstable before ready");
      if (viol[2]) $error("multisim_axi_outstanding_limiter: B unstable before ready");
      if (viol[3]) $error("multisim_axi_outstanding_limiter: AR unstable before ready");
      if (viol[4]) $error("multisim_axi_outstanding_limiter: R unstable before ready");
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_multisim_axi_outstanding_limiter.sv
// tb/tb_multisim_axi_outstanding_limiter.sv - directed self-checking bench for the AXI outstanding limiter
module tb_multisim_axi_outstanding_limiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] i_axi_s_aw;
  logic        i_axi_s_awvalid;
  logic        o_axi_s_awready;
  logic [72:0] i_axi_s_w;
  logic        i_axi_s_wvalid;
  logic        o_axi_s_wready;
  logic [5:0]  o_axi_s_b;
  logic        o_axi_s_bvalid;
  logic        i_axi_s_bready;
  logic [63:0] i_axi_s_ar;
  logic        i_axi_s_arvalid;
  logic        o_axi_s_arready;
  logic [70:0] o_axi_s_r;
  logic        o_axi_s_rvalid;
  logic        i_axi_s_rready;
  logic [63:0] o_axi_m_aw;
  logic        o_axi_m_awvalid;
  logic        i_axi_m_awready;
  logic [72:0] o_axi_m_w;
  logic        o_axi_m_wvalid;
  logic        i_axi_m_wready;
  logic [5:0]  i_axi_m_b;
  logic        i_axi_m_bvalid;
  logic        o_axi_m_bready;
  logic [63:0] o_axi_m_ar;
  logic        o_axi_m_arvalid;
  logic        i_axi_m_arready;
  logic [70:0] i_axi_m_r;
  logic        i_axi_m_rvalid;
  logic        o_axi_m_rready;
  logic        o_err;

  int checks = 0;
  int errors = 0;
  int acc;
  int sent;
  int w_rx, w_bad, w_stall_bad;
  logic        w_pend = 1'b0;
  logic [72:0] w_prev = '0;
  logic        hs;
  logic        exp_err;
  logic [63:0] aw_q[$];
  logic [70:0] r_q[$];

  multisim_axi_outstanding_limiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_axi_s_aw(i_axi_s_aw), .i_axi_s_awvalid(i_axi_s_awvalid), .o_axi_s_awready(o_axi_s_awready),
    .i_axi_s_w(i_axi_s_w), .i_axi_s_wvalid(i_axi_s_wvalid), .o_axi_s_wready(o_axi_s_wready),
    .o_axi_s_b(o_axi_s_b), .o_axi_s_bvalid(o_axi_s_bvalid), .i_axi_s_bready(i_axi_s_bready),
    .i_axi_s_ar(i_axi_s_ar), .i_axi_s_arvalid(i_axi_s_arvalid), .o_axi_s_arready(o_axi_s_arready),
    .o_axi_s_r(o_axi_s_r), .o_axi_s_rvalid(o_axi_s_rvalid), .i_axi_s_rready(i_axi_s_rready),
    .o_axi_m_aw(o_axi_m_aw), .o_axi_m_awvalid(o_axi_m_awvalid), .i_axi_m_awready(i_axi_m_awready),
    .o_axi_m_w(o_axi_m_w), .o_axi_m_wvalid(o_axi_m_wvalid), .i_axi_m_wready(i_axi_m_wready),
    .i_axi_m_b(i_axi_m_b), .i_axi_m_bvalid(i_axi_m_bvalid), .o_axi_m_bready(o_axi_m_bready),
    .o_axi_m_ar(o_axi_m_ar), .o_axi_m_arvalid(o_axi_m_arvalid), .i_axi_m_arready(i_axi_m_arready),
    .i_axi_m_r(i_axi_m_r), .i_axi_m_rvalid(i_axi_m_rvalid), .o_axi_m_rready(o_axi_m_rready),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_aw(input int n);
    for (int i = 0; i < n; i++) begin
      i_axi_s_awvalid = (acc < 7);
      i_axi_s_aw      = 64'(100 + acc);
      hs              = o_axi_s_awready && i_axi_s_awvalid;
      tick();
      if (hs) acc++;
    end
    i_axi_s_awvalid = 1'b0;
  endtask

  function automatic logic [70:0] r_pay(input int b);
    return 71'((b << 1) | (((b % 4) == 3) ? 1 : 0));
  endfunction

  // handshake monitors sample mid-cycle, where inputs and outputs are both settled
  always @(negedge clk) begin
    if (o_axi_m_awvalid && i_axi_m_awready) aw_q.push_back(o_axi_m_aw);
    if (o_axi_s_rvalid && i_axi_s_rready) r_q.push_back(o_axi_s_r);
    if (w_pend && (!o_axi_m_wvalid || o_axi_m_w != w_prev)) w_stall_bad++;
    if (o_axi_m_wvalid && i_axi_m_wready) begin
      if (o_axi_m_w != 73'(w_rx)) w_bad++;
      w_rx++;
    end
    w_pend = o_axi_m_wvalid && !i_axi_m_wready;
    w_prev = o_axi_m_w;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    i_axi_s_aw = '0; i_axi_s_awvalid = 1'b0; i_axi_s_w = '0; i_axi_s_wvalid = 1'b0;
    i_axi_s_bready = 1'b1; i_axi_s_ar = '0; i_axi_s_arvalid = 1'b0; i_axi_s_rready = 1'b1;
    i_axi_m_awready = 1'b1; i_axi_m_wready = 1'b1; i_axi_m_b = '0; i_axi_m_bvalid = 1'b0;
    i_axi_m_arready = 1'b1; i_axi_m_r = '0; i_axi_m_rvalid = 1'b0;
    repeat (2) tick();
    check("rst_s_awready", o_axi_s_awready, 0);
    check("rst_m_bready", o_axi_m_bready, 0);
    check("rst_m_awvalid", o_axi_m_awvalid, 0);
    check("rst_s_bvalid", o_axi_s_bvalid, 0);
    check("rst_err", o_err, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_s_awready", o_axi_s_awready, 1);
    check("post_rst_wr_cnt", dut.wr_cnt, 0);

    // single write
    i_axi_s_aw = 64'hA1; i_axi_s_awvalid = 1'b1;
    i_axi_s_w = 73'h1F1; i_axi_s_wvalid = 1'b1;
    tick();
    i_axi_s_awvalid = 1'b0; i_axi_s_wvalid = 1'b0;
    check("t1_m_awvalid", o_axi_m_awvalid, 1);
    check("t1_m_aw", o_axi_m_aw, 64'hA1);
    check("t1_m_wvalid", o_axi_m_wvalid, 1);
    check("t1_m_w", o_axi_m_w, 73'h1F1);
    check("t1_cnt0", dut.wr_cnt, 0);
    tick();
    check("t1_cnt1", dut.wr_cnt, 1);
    check("t1_m_awvalid_done", o_axi_m_awvalid, 0);
    i_axi_m_b = 6'h15; i_axi_m_bvalid = 1'b1;
    tick();
    i_axi_m_bvalid = 1'b0;
    check("t1_s_bvalid", o_axi_s_bvalid, 1);
    check("t1_s_b", o_axi_s_b, 6'h15);
    check("t1_cnt_back", dut.wr_cnt, 0);

    // write limit with B withheld
    aw_q.delete();
    acc = 0;
    run_aw(12);
    check("t2_accepted", acc, 6);
    check("t2_m_aw_count", aw_q.size(), 4);
    check("t2_first_aw", aw_q[0], 100);
    check("t2_fourth_aw", aw_q[3], 103);
    check("t2_s_awready", o_axi_s_awready, 0);
    check("t2_wr_cnt", dut.wr_cnt, 4);
    check("t2_m_awvalid", o_axi_m_awvalid, 0);
    i_axi_m_bvalid = 1'b1;
    tick();
    i_axi_m_bvalid = 1'b0;
    check("t2_fifth_valid", o_axi_m_awvalid, 1);
    check("t2_fifth_aw", o_axi_m_aw, 104);
    run_aw(4);
    check("t2_all_accepted", acc, 7);
    check("t2_m_aw_count5", aw_q.size(), 5);
    check("t2_wr_cnt_refull", dut.wr_cnt, 4);

    // B alone, then AW and B together, then AW alone
    i_axi_m_bvalid = 1'b1;
    tick();
    tick();
    i_axi_m_bvalid = 1'b0;
    check("t5_simul_cnt", dut.wr_cnt, 3);
    tick();
    check("t5_final_cnt", dut.wr_cnt, 4);
    check("t5_m_aw_count", aw_q.size(), 7);
    check("t5_last_aw", aw_q[6], 106);

    // two reads, 4-beat bursts
    i_axi_s_ar = 64'h1; i_axi_s_arvalid = 1'b1;
    tick();
    i_axi_s_ar = 64'h2;
    tick();
    i_axi_s_arvalid = 1'b0;
    tick();
    check("t3_rd_cnt2", dut.rd_cnt, 2);
    r_q.delete();
    for (int b = 0; b < 8; b++) begin
      i_axi_m_r = r_pay(b); i_axi_m_rvalid = 1'b1;
      tick();
      if (b == 2) check("t3_rd_before_last", dut.rd_cnt, 2);
      if (b == 3) check("t3_rd_after_last1", dut.rd_cnt, 1);
      if (b == 6) check("t3_rd_mid_burst2", dut.rd_cnt, 1);
      if (b == 7) check("t3_rd_after_last2", dut.rd_cnt, 0);
    end
    i_axi_m_rvalid = 1'b0;
    repeat (3) tick();
    check("t3_r_count", r_q.size(), 8);
    check("t3_r_first", r_q[0], r_pay(0));
    check("t3_r_last", r_q[7], r_pay(7));

    // random backpressure on the W path
    w_rx = 0; w_bad = 0; w_stall_bad = 0; sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      i_axi_m_wready = 1'($urandom_range(0, 1));
      i_axi_s_w = 73'(sent); i_axi_s_wvalid = 1'b1;
      hs = o_axi_s_wready;
      tick();
      if (hs) sent++;
    end
    i_axi_s_wvalid = 1'b0; i_axi_m_wready = 1'b1;
    repeat (4) tick();
    check("t4_sent", sent, 1000);
    check("t4_received", w_rx, 1000);
    check("t4_order_errs", w_bad, 0);
    check("t4_stall_errs", w_stall_bad, 0);

    // reset with beats buffered
    i_axi_m_wready = 1'b0; i_axi_s_w = 73'h55; i_axi_s_wvalid = 1'b1;
    i_axi_s_aw = 64'hC8; i_axi_s_awvalid = 1'b1;
    tick();
    check("t6_pre_m_wvalid", o_axi_m_wvalid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_m_wvalid", o_axi_m_wvalid, 0);
    check("t6_rst_s_awready", o_axi_s_awready, 0);
    check("t6_rst_wr_cnt", dut.wr_cnt, 0);
    i_axi_s_wvalid = 1'b0; i_axi_s_awvalid = 1'b0; i_axi_m_wready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_post_s_awready", o_axi_s_awready, 1);
    check("t6_post_m_wvalid", o_axi_m_wvalid, 0);
    check("t6_post_wr_cnt", dut.wr_cnt, 0);
    check("t6_post_rd_cnt", dut.rd_cnt, 0);

    // responses with nothing outstanding
`ifdef MULTISIM_AXI_LIMITER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check("udf_err_before", o_err, 0);
    i_axi_m_b = 6'h3; i_axi_m_bvalid = 1'b1;
    tick();
    i_axi_m_bvalid = 1'b0;
    check("udf_wr_cnt", dut.wr_cnt, 0);
    check("udf_err", o_err, exp_err);
    check("udf_b_passes", o_axi_s_bvalid, 1);
    i_axi_m_r = 71'h1; i_axi_m_rvalid = 1'b1;
    tick();
    i_axi_m_rvalid = 1'b0;
    check("udf_rd_cnt", dut.rd_cnt, 0);
    tick();
    check("udf_err_sticky", o_err, exp_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
